axi_lite_cfg_master: RTL

AXI_LITE_CFG_MASTER -- requirements
Module: axi_lite_cfg_master

---
 rtl/ac_lite_pkg.sv | 25 ++
 rtl/lite_watchdog.sv | 45 ++++
 rtl/axi_lite_cfg_master.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ac_lite_pkg.sv
// Shared types and constants for the AXI4-Lite configuration master.
package ac_lite_pkg;

    localparam int unsigned AcDataWidth     = 32;
    localparam int unsigned AcAddrWidth     = 32;
    localparam int unsigned AcTimeoutCycles = 1024;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StDone
    } ac_state_e;

    // States in which the master is waiting on the slave and the watchdog runs.
    function automatic logic is_wait_state(input ac_state_e s);
        return (s == StWrReq) || (s == StWrResp) || (s == StRdReq) || (s == StRdData);
    endfunction

endpackage

// File: rtl/lite_watchdog.sv
// Saturating per-state cycle counter with a sticky expiry flag.
module lite_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_restart,
    output logic o_expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_count_next;
    logic            r_expired;

    // Count is the 1-based index of the current cycle in a wait state, 0 otherwise.
    always_comb begin
        w_count_next = '0;
        if (i_active) begin
            if (i_restart) begin
                w_count_next = CntW'(1);
            end else if (r_count < Limit) begin
                w_count_next = r_count + CntW'(1);
            end else begin
                w_count_next = r_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_expired <= r_expired | (w_count_next >= Limit);
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite master turning cmd requests into register reads/writes.
module axi_lite_cfg_master
    import ac_lite_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = AcDataWidth,
    parameter int unsigned AXI_ADDR_WIDTH = AcAddrWidth,
    parameter int unsigned TIMEOUT_CYCLES = AcTimeoutCycles
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        timeout_err,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp
);

    ac_state_e r_state;
    ac_state_e w_state_next;

    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic                        r_aw_done;
    logic                        r_w_done;
    logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]                  r_rsp_resp;

    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_hs;

    assign cmd_ready     = (r_state == StIdle) && !rst;
    assign m_axi_awvalid = (r_state == StWrReq) && !r_aw_done;
    assign m_axi_wvalid  = (r_state == StWrReq) && !r_w_done;
    assign m_axi_bready  = (r_state == StWrResp);
    assign m_axi_arvalid = (r_state == StRdReq);
    assign m_axi_rready  = (r_state == StRdData);
    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign rsp_valid     = (r_state == StDone);
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_w_hs   = m_axi_wvalid && m_axi_wready;
    assign w_b_hs   = m_axi_bvalid && m_axi_bready;
    assign w_r_hs   = m_axi_rvalid && m_axi_rready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_cmd_hs) begin
                    w_state_next = cmd_write ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                // AW and W may complete in either order or together.
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = StWrResp;
                end
            end
            StWrResp: begin
                if (w_b_hs) begin
                    w_state_next = StDone;
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    w_state_next = StRdData;
                end
            end
            StRdData: begin
                if (w_r_hs) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RespOkay;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_hs) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end
            if (w_b_hs) begin
                r_rsp_rdata <= '0;
                r_rsp_resp  <= m_axi_bresp;
            end
            if (w_r_hs) begin
                r_rsp_rdata <= m_axi_rdata;
                r_rsp_resp  <= m_axi_rresp;
            end
        end
    end

    lite_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_active (is_wait_state(w_state_next)),
        .i_restart(w_state_next != r_state),
        .o_expired(timeout_err)
    );

endmodule
